// File: rtl/video_scanout.sv
// video_scanout: framebuffer scanout stage.
// Prefetches each active line (RGB332, 4 px per word) into a ping-pong line
// buffer over a valid/ready master port and emits pixel-aligned RGB565.
// Optional feature macro: VIDEO_SCANOUT_PALETTE_EN adds a 256x16 palette RAM
// indexed by the pixel byte in a third pipeline stage (latency 3 instead of 2).
//
// Handshake: mem_valid is raised with a stable mem_addr and held until the
// cycle in which mem_ready is high; that cycle transfers mem_rdata and the
// request either advances to the next word or drops.
module video_scanout #(
    parameter logic [31:0] FB_BASE  = 32'h0001_0000,
    parameter int          H_ACTIVE = 640,
    parameter int          V_ACTIVE = 480
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               data_en_in,
    input  logic signed [15:0] xpos,
    input  logic signed [15:0] ypos,
    output logic               mem_valid,
    output logic [31:0]        mem_addr,
    input  logic               mem_ready,
    input  logic [31:0]        mem_rdata,
    output logic               hsync,
    output logic               vsync,
    output logic               data_en,
    output logic [15:0]        rgb,
    output logic               underrun,
    input  logic               underrun_clr
`ifdef VIDEO_SCANOUT_PALETTE_EN
    ,
    input  logic               pal_we,
    input  logic [7:0]         pal_addr,
    input  logic [15:0]        pal_wdata
`endif
);

    localparam int WORDS = H_ACTIVE / 4;
    localparam int KW    = $clog2(WORDS);
    localparam int IDX_W = $clog2(2 * WORDS);
`ifdef VIDEO_SCANOUT_PALETTE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam logic [KW-1:0]     K_LAST = KW'(WORDS - 1);
    localparam logic signed [15:0] Y_LAST = 16'(V_ACTIVE - 2);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    // Fetch state
    state_t        r_state;
    logic          r_valid;
    logic [31:0]   r_addr;
    logic [KW-1:0] r_k;
    logic          r_bank;
    logic          r_pend;
    logic [31:0]   r_pend_base;
    logic          r_pend_bank;
    logic          r_underrun;

    // Line buffer and display pipeline
    logic [31:0]    r_lbuf [0:2*WORDS-1];
    logic [31:0]    r_p1_word;
    logic [1:0]     r_p1_sel;
    logic [LAT-1:0] r_hs_pipe;
    logic [LAT-1:0] r_vs_pipe;
    logic [LAT-1:0] r_de_pipe;
    logic [15:0]    r_rgb;

    logic             w_trigger;
    logic [15:0]      w_next_line;
    logic [31:0]      w_next_base;
    logic             w_accept;
    logic [IDX_W-1:0] w_wr_idx;
    logic [7:0]       w_rd_word;
    logic             w_rd_ok;
    logic [IDX_W-1:0] w_rd_idx;
    logic [7:0]       w_byte;

    // A fetch is due when the timing generator starts the line before the target line
    assign w_trigger   = (xpos == 16'sd0) && (ypos >= -16'sd1) && (ypos <= Y_LAST);
    assign w_next_line = ypos + 16'sd1;
    assign w_next_base = FB_BASE + 32'(w_next_line) * 32'(H_ACTIVE);
    assign w_accept    = r_valid && mem_ready;
    assign w_wr_idx    = IDX_W'(r_k) + (r_bank ? IDX_W'(WORDS) : IDX_W'(0));

    assign w_rd_word = xpos[9:2];
    assign w_rd_ok   = 32'(w_rd_word) < 32'(WORDS);
    assign w_rd_idx  = IDX_W'(w_rd_word) + (ypos[0] ? IDX_W'(WORDS) : IDX_W'(0));
    assign w_byte    = r_p1_word[{r_p1_sel, 3'b000} +: 8];

`ifndef VIDEO_SCANOUT_PALETTE_EN
    function automatic logic [15:0] rgb332_to_565(input logic [7:0] b);
        return {b[7:5], b[7:6], b[4:2], b[4:2], b[1:0], b[1:0], b[1]};
    endfunction
`endif

    // Fetch FSM: walks the words of one line; a trigger mid-line is queued
    // behind the in-flight handshake and restarts at word 0 without idling.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_valid     <= 1'b0;
            r_addr      <= 32'd0;
            r_k         <= '0;
            r_bank      <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_base <= 32'd0;
            r_pend_bank <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        r_state <= S_REQ;
                        r_valid <= 1'b1;
                        r_k     <= '0;
                        r_bank  <= w_next_line[0];
                        r_addr  <= w_next_base;
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        if (w_trigger) begin
                            r_k    <= '0;
                            r_bank <= w_next_line[0];
                            r_addr <= w_next_base;
                            r_pend <= 1'b0;
                        end else if (r_pend) begin
                            r_k    <= '0;
                            r_bank <= r_pend_bank;
                            r_addr <= r_pend_base;
                            r_pend <= 1'b0;
                        end else if (r_k == K_LAST) begin
                            r_state <= S_IDLE;
                            r_valid <= 1'b0;
                        end else begin
                            r_k    <= r_k + KW'(1);
                            r_addr <= r_addr + 32'd4;
                        end
                    end else if (w_trigger) begin
                        r_pend      <= 1'b1;
                        r_pend_base <= w_next_base;
                        r_pend_bank <= w_next_line[0];
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // Sticky underrun flag: a new line arrived before the previous fetch finished
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_underrun <= 1'b0;
        end else if (w_trigger && (r_state == S_REQ)) begin
            r_underrun <= 1'b1;
        end else if (underrun_clr) begin
            r_underrun <= 1'b0;
        end
    end

    // Line buffer write port and P1 read (no reset so it maps onto RAM)
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lbuf[w_wr_idx] <= mem_rdata;
        end
        r_p1_word <= w_rd_ok ? r_lbuf[w_rd_idx] : 32'd0;
    end

`ifdef VIDEO_SCANOUT_PALETTE_EN
    logic [15:0] r_pal [0:255];
    logic [7:0]  r_p2_byte;

    // Palette RAM write port; a write is visible to the next cycle's lookup
    always_ff @(posedge clk) begin
        if (pal_we) begin
            r_pal[pal_addr] <= pal_wdata;
        end
    end
`endif

    // Display pipeline: byte select alongside the P1 word, colour out with sync delay matched
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_p1_sel  <= 2'd0;
            r_hs_pipe <= '0;
            r_vs_pipe <= '0;
            r_de_pipe <= '0;
            r_rgb     <= 16'h0000;
`ifdef VIDEO_SCANOUT_PALETTE_EN
            r_p2_byte <= 8'd0;
`endif
        end else begin
            r_p1_sel  <= xpos[1:0];
            r_hs_pipe <= {r_hs_pipe[LAT-2:0], hsync_in};
            r_vs_pipe <= {r_vs_pipe[LAT-2:0], vsync_in};
            r_de_pipe <= {r_de_pipe[LAT-2:0], data_en_in};
`ifdef VIDEO_SCANOUT_PALETTE_EN
            r_p2_byte <= w_byte;
            r_rgb     <= r_de_pipe[1] ? r_pal[r_p2_byte] : 16'h0000;
`else
            r_rgb     <= r_de_pipe[0] ? rgb332_to_565(w_byte) : 16'h0000;
`endif
        end
    end

    assign mem_valid = r_valid;
    assign mem_addr  = r_addr;
    assign underrun  = r_underrun;
    assign hsync     = r_hs_pipe[LAT-1];
    assign vsync     = r_vs_pipe[LAT-1];
    assign data_en   = r_de_pipe[LAT-1];
    assign rgb       = r_rgb;

endmodule
